// File: rtl/m_memarb_pkg.sv
// Shared defaults and helpers for the unified instruction/data memory arbiter.
package m_memarb_pkg;
  localparam int AW_DEF     = 12;
  localparam int DW_DEF     = 32;
  localparam int STARVE_DEF = 4;
  localparam int MEM_WORDS  = 4096;

  typedef enum logic [1:0] {
    PICK_NONE,
    PICK_FETCH,
    PICK_DATA
  } pick_e;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction
endpackage

// File: rtl/m_memarb_if.sv
// Request/grant, read-return and RAM-side signals between the pipeline, the arbiter and the RAM.
interface m_memarb_if
  import m_memarb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          w_ireq;
  logic [AW-1:0] w_iaddr;
  logic          w_igrant;
  logic          r_ivalid;
  logic [DW-1:0] w_idata;
  logic          w_dreq;
  logic          w_dwe;
  logic [AW-1:0] w_daddr;
  logic [DW-1:0] w_dwdata;
  logic          w_dgrant;
  logic          r_dvalid;
  logic [DW-1:0] w_ddata;
  logic [AW-1:0] w_maddr;
  logic          w_mwe;
  logic [DW-1:0] w_mwdata;
  logic [DW-1:0] w_mrdata;

  modport slave (
    input  w_ireq, w_iaddr, w_dreq, w_dwe, w_daddr, w_dwdata, w_mrdata,
    output w_igrant, r_ivalid, w_idata, w_dgrant, r_dvalid, w_ddata,
           w_maddr, w_mwe, w_mwdata
  );

  modport master (
    output w_ireq, w_iaddr, w_dreq, w_dwe, w_daddr, w_dwdata, w_mrdata,
    input  w_igrant, r_ivalid, w_idata, w_dgrant, r_dvalid, w_ddata,
           w_maddr, w_mwe, w_mwdata
  );
endinterface

// File: rtl/m_memarb_starve.sv
// Two-way pick with data priority; fetch wins after STARVE consecutive data grants.
module m_arb2_starve
  import m_memarb_pkg::*;
#(
  parameter int STARVE = STARVE_DEF
) (
  input  logic w_clk,
  input  logic w_rst_n,
  input  logic i_ireq,
  input  logic i_dreq,
  output logic o_gnt_i,
  output logic o_gnt_d
);
  localparam logic [3:0] LIM = 4'(STARVE);

  logic [3:0] r_scnt;
  pick_e      w_pick;

  always_comb begin
    w_pick = PICK_NONE;
    if (i_dreq && i_ireq)
      w_pick = (r_scnt >= LIM) ? PICK_FETCH : PICK_DATA;
    else if (i_dreq)
      w_pick = PICK_DATA;
    else if (i_ireq)
      w_pick = PICK_FETCH;
  end

  // Grants are suppressed for the whole time reset is held.
  assign o_gnt_i = w_rst_n && (w_pick == PICK_FETCH);
  assign o_gnt_d = w_rst_n && (w_pick == PICK_DATA);

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n)
      r_scnt <= 4'd0;
    else if (!i_ireq || o_gnt_i)
      r_scnt <= 4'd0;
    else if (o_gnt_d)
      r_scnt <= sat_inc4(r_scnt, LIM);
  end
endmodule

// File: rtl/m_memarb.sv
// Unified memory arbiter: one single-port RAM shared by instruction fetch and load/store.
module m_memarb
  import m_memarb_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int STARVE = STARVE_DEF
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  m_memarb_if.slave   bus,
  output logic [31:0] r_nconf
);
  logic w_gnt_i;
  logic w_gnt_d;

  m_arb2_starve #(.STARVE(STARVE)) u_arb (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .i_ireq  (bus.w_ireq),
    .i_dreq  (bus.w_dreq),
    .o_gnt_i (w_gnt_i),
    .o_gnt_d (w_gnt_d)
  );

  assign bus.w_igrant = w_gnt_i;
  assign bus.w_dgrant = w_gnt_d;

  // Fetch address is presented whenever data is not granted; write data always passes through.
  assign bus.w_maddr  = w_gnt_d ? bus.w_daddr : bus.w_iaddr;
  assign bus.w_mwe    = w_gnt_d & bus.w_dwe;
  assign bus.w_mwdata = bus.w_dwdata;

  assign bus.w_idata  = bus.w_mrdata;
  assign bus.w_ddata  = bus.w_mrdata;

  logic r_ivalid;
  logic r_dvalid;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ivalid <= 1'b0;
      r_dvalid <= 1'b0;
      r_nconf  <= 32'd0;
    end else begin
      r_ivalid <= w_gnt_i;
      r_dvalid <= w_gnt_d & ~bus.w_dwe;
      if (bus.w_ireq && bus.w_dreq)
        r_nconf <= r_nconf + 32'd1;
    end
  end

  assign bus.r_ivalid = r_ivalid;
  assign bus.r_dvalid = r_dvalid;
endmodule

// File: tb/tb_m_memarb.sv
// Directed bench for m_memarb with a behavioural 1-cycle registered RAM preloaded RAM[k]=k.
`timescale 1ns/1ps
module tb_m_memarb;
  import m_memarb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;

  logic        w_clk = 1'b0;
  logic        w_rst_n = 1'b0;
  logic [31:0] r_nconf;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [DW-1:0] mem [MEM_WORDS];

  m_memarb_if #(.AW(AW), .DW(DW)) bus ();

  m_memarb #(.AW(AW), .DW(DW), .STARVE(4)) dut (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .bus     (bus),
    .r_nconf (r_nconf)
  );

  always #5 w_clk = ~w_clk;

  // RAM model: registered read, read returns old data when written in the same cycle.
  always @(posedge w_clk) begin
    bus.w_mrdata <= mem[bus.w_maddr];
    if (bus.w_mwe) mem[bus.w_maddr] <= bus.w_mwdata;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge w_clk);
  endtask

  task automatic after_pos();
    @(posedge w_clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.w_ireq = 1'b0; bus.w_iaddr = '0;
    bus.w_dreq = 1'b0; bus.w_dwe = 1'b0; bus.w_daddr = '0; bus.w_dwdata = '0;
  endtask

  // Expected grant pattern for the starvation test: 1 = fetch, 0 = data.
  logic [9:0] starve_pat;

  initial begin
    for (int k = 0; k < MEM_WORDS; k++) mem[k] = DW'(k);
    bus.w_mrdata = '0;
    idle_bus();

    // Reset state: grants held low even with both requests up.
    bus.w_ireq = 1'b1; bus.w_dreq = 1'b1;
    to_neg();
    chk("rst_igrant", bus.w_igrant, 0);
    chk("rst_dgrant", bus.w_dgrant, 0);
    chk("rst_ivalid", bus.r_ivalid, 0);
    chk("rst_dvalid", bus.r_dvalid, 0);
    chk("rst_nconf",  r_nconf, 0);
    idle_bus();
    after_pos(); after_pos();
    w_rst_n = 1'b1;

    // 1. Fetch only, addresses 0..7.
    for (int i = 0; i < 8; i++) begin
      bus.w_ireq = 1'b1; bus.w_iaddr = AW'(i);
      to_neg();
      chk($sformatf("f_igrant%0d", i), bus.w_igrant, 1);
      chk($sformatf("f_maddr%0d", i), bus.w_maddr, i);
      after_pos();
      chk($sformatf("f_ivalid%0d", i), bus.r_ivalid, 1);
      chk($sformatf("f_idata%0d", i), bus.w_idata, i);
    end
    idle_bus();
    after_pos();
    chk("f_ivalid_off", bus.r_ivalid, 0);

    // 2. Store 0xdead to 5, then load 5.
    bus.w_dreq = 1'b1; bus.w_dwe = 1'b1; bus.w_daddr = 12'd5; bus.w_dwdata = 32'hdead;
    to_neg();
    chk("st_dgrant", bus.w_dgrant, 1);
    chk("st_mwe",    bus.w_mwe, 1);
    chk("st_maddr",  bus.w_maddr, 5);
    after_pos();
    chk("st_dvalid", bus.r_dvalid, 0);
    bus.w_dwe = 1'b0;
    to_neg();
    chk("ld_dgrant", bus.w_dgrant, 1);
    chk("ld_mwe",    bus.w_mwe, 0);
    after_pos();
    chk("ld_dvalid", bus.r_dvalid, 1);
    chk("ld_ddata",  bus.w_ddata, 32'hdead);
    chk("ld_ivalid", bus.r_ivalid, 0);
    idle_bus();
    after_pos();

    // 3. Starvation: fetch at 3 waits behind a stream of loads from 9.
    chk("sv_nconf0", r_nconf, 0);
    starve_pat = 10'b10000_10000;
    bus.w_ireq = 1'b1; bus.w_iaddr = 12'd3;
    bus.w_dreq = 1'b1; bus.w_dwe = 1'b0; bus.w_daddr = 12'd9;
    for (int c = 0; c < 10; c++) begin
      to_neg();
      chk($sformatf("sv_igrant%0d", c), bus.w_igrant, starve_pat[c]);
      chk($sformatf("sv_dgrant%0d", c), bus.w_dgrant, !starve_pat[c]);
      after_pos();
      if (starve_pat[c]) begin
        chk($sformatf("sv_ivalid%0d", c), bus.r_ivalid, 1);
        chk($sformatf("sv_idata%0d", c), bus.w_idata, 3);
      end else begin
        chk($sformatf("sv_dvalid%0d", c), bus.r_dvalid, 1);
        chk($sformatf("sv_ddata%0d", c), bus.w_ddata, 9);
      end
    end
    idle_bus();
    chk("sv_nconf", r_nconf, 10);
    after_pos();

    // 4. One simultaneous cycle with the counter at zero.
    chk("sim_scnt0", dut.u_arb.r_scnt, 0);
    bus.w_ireq = 1'b1; bus.w_iaddr = 12'd2;
    bus.w_dreq = 1'b1; bus.w_dwe = 1'b0; bus.w_daddr = 12'd4;
    to_neg();
    chk("sim_dgrant", bus.w_dgrant, 1);
    chk("sim_igrant", bus.w_igrant, 0);
    after_pos();
    chk("sim_scnt1", dut.u_arb.r_scnt, 1);
    bus.w_dreq = 1'b0;
    to_neg();
    chk("sim_igrant2", bus.w_igrant, 1);
    chk("sim_maddr2", bus.w_maddr, 2);
    after_pos();
    chk("sim_ivalid", bus.r_ivalid, 1);
    chk("sim_idata",  bus.w_idata, 2);
    chk("sim_scnt2",  dut.u_arb.r_scnt, 0);
    chk("sim_nconf",  r_nconf, 11);
    idle_bus();

    // 5. Reset while a load is granted, before its accepting edge.
    bus.w_dreq = 1'b1; bus.w_dwe = 1'b0; bus.w_daddr = 12'd7; bus.w_ireq = 1'b1;
    to_neg();
    chk("rs_dgrant", bus.w_dgrant, 1);
    #1 w_rst_n = 1'b0;
    #1;
    chk("rs_dgrant_rst", bus.w_dgrant, 0);
    chk("rs_nconf_rst",  r_nconf, 0);
    after_pos();
    chk("rs_dvalid_rst", bus.r_dvalid, 0);
    idle_bus();
    after_pos();
    #2 w_rst_n = 1'b1;
    after_pos();
    chk("rs_dvalid", bus.r_dvalid, 0);
    chk("rs_ivalid", bus.r_ivalid, 0);
    chk("rs_nconf",  r_nconf, 0);
    chk("rs_scnt",   dut.u_arb.r_scnt, 0);

    // 6. Idle: nothing granted, nothing written.
    for (int c = 0; c < 5; c++) begin
      to_neg();
      chk($sformatf("id_igrant%0d", c), bus.w_igrant, 0);
      chk($sformatf("id_dgrant%0d", c), bus.w_dgrant, 0);
      chk($sformatf("id_mwe%0d", c),    bus.w_mwe, 0);
    end
    after_pos();
    chk("id_mem5",  mem[5], 32'hdead);
    chk("id_mem0",  mem[0], 0);
    chk("id_mem7",  mem[7], 7);
    chk("id_nconf", r_nconf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
endmodule
